// File: rtl/monitor_counters_sampler.sv
// Purpose: register-bus master that sweeps the counter block (read, optional clear) into one atomic snapshot.
// Latency: start -> first request 1 cycle; zero-wait sweep 2*NUM_CNT+1 cycles, 4*NUM_CNT+1 with clear.
// Backpressure: requests held stable until rsp_ready_i; starts arriving while busy are dropped and flagged on overrun_o.
module monitor_counters_sampler #(
  parameter int AW        = 6,
  parameter int DW        = 32,
  parameter int NUM_CNT   = 8,
  parameter int BASE_ADDR = 0,
  parameter int PERIOD_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [PERIOD_W-1:0]   period_i,
  input  logic                  trigger_i,
  input  logic                  clear_after_read_i,
  output logic                  req_valid_o,
  output logic                  req_write_o,
  output logic [AW-1:0]         req_addr_o,
  output logic [DW-1:0]         req_wdata_o,
  output logic [DW/8-1:0]       req_wstrb_o,
  input  logic                  rsp_ready_i,
  input  logic [DW-1:0]         rsp_rdata_i,
  input  logic                  rsp_error_i,
  output logic [NUM_CNT*DW-1:0] snap_data_o,
  output logic                  snap_valid_o,
  output logic                  snap_error_o,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [15:0]           sample_cnt_o
);

  localparam int            IW       = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CNT - 1);
  localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ, CLEAR, DONE} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx;
  logic                  clr_flag;
  logic                  err_flag;
  logic                  enable_q;
  logic [PERIOD_W-1:0]   timer;
  logic [PERIOD_W-1:0]   reload_val;
  logic [NUM_CNT*DW-1:0] shadow;
  logic [AW-1:0]         idx_addr;

  logic tmr_run, enable_rise, tmr_expire, start_evt, xfer, last_idx;
  logic accept, issue, issue_write, idx_inc, done;

  // The enable edge reloads the timer, so it must not also count as an expiry:
  // the first periodic start comes a full period after enable rises.
  assign tmr_run     = enable_i && (period_i != '0);
  assign enable_rise = enable_i && !enable_q;
  assign tmr_expire  = tmr_run && (timer == '0) && !enable_rise;
  assign start_evt   = trigger_i || tmr_expire;
  assign xfer        = req_valid_o && rsp_ready_i;
  assign last_idx    = (idx == LAST_IDX);
  assign idx_addr    = BASE + AW'({idx, 2'b00});
  assign reload_val  = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
  assign req_wdata_o = '0;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and sweep control strobes; a new request is issued only when none is outstanding,
  // which leaves one idle bus cycle after every completion.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    issue       = 1'b0;
    issue_write = 1'b0;
    idx_inc     = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_nxt = READ;
          accept    = 1'b1;
        end
      end
      READ: begin
        if (!req_valid_o) begin
          issue = 1'b1;
        end else if (rsp_ready_i) begin
          if (clr_flag)      state_nxt = CLEAR;
          else if (last_idx) state_nxt = DONE;
          else               idx_inc   = 1'b1;
        end
      end
      CLEAR: begin
        if (!req_valid_o) begin
          issue       = 1'b1;
          issue_write = 1'b1;
        end else if (rsp_ready_i) begin
          if (last_idx) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
            idx_inc   = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered bus request, sweep index, latched clear flag and sweep error accumulation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_o <= 1'b0;
      req_write_o <= 1'b0;
      req_addr_o  <= '0;
      req_wstrb_o <= '0;
      idx         <= '0;
      clr_flag    <= 1'b0;
      err_flag    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      if (accept) begin
        req_valid_o <= 1'b1;
        req_write_o <= 1'b0;
        req_addr_o  <= BASE;
        req_wstrb_o <= '0;
        idx         <= '0;
        clr_flag    <= clear_after_read_i;
        err_flag    <= 1'b0;
        busy_o      <= 1'b1;
      end else if (issue) begin
        req_valid_o <= 1'b1;
        req_write_o <= issue_write;
        req_addr_o  <= idx_addr;
        req_wstrb_o <= {(DW/8){issue_write}};
      end else if (xfer) begin
        req_valid_o <= 1'b0;
        err_flag    <= err_flag | rsp_error_i;
      end
      if (idx_inc) idx <= idx + IW'(1);
      if (done)    busy_o <= 1'b0;
    end
  end

  // Shadow capture per read; the whole shadow is published at once when the sweep finishes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow       <= '0;
      snap_data_o  <= '0;
      snap_valid_o <= 1'b0;
      snap_error_o <= 1'b0;
      sample_cnt_o <= '0;
    end else begin
      snap_valid_o <= done;
      if (xfer && !req_write_o) shadow[idx*DW +: DW] <= rsp_rdata_i;
      if (done) begin
        snap_data_o  <= shadow;
        snap_error_o <= err_flag;
        sample_cnt_o <= sample_cnt_o + 16'd1;
      end
    end
  end

  // Period timer: reloads on any start (accepted or dropped) and on the enable edge, otherwise counts down while running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer     <= '0;
      enable_q  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      enable_q  <= enable_i;
      overrun_o <= start_evt && (state != IDLE);
      if (start_evt || enable_rise)    timer <= reload_val;
      else if (tmr_run && timer != '0) timer <= timer - PERIOD_W'(1);
    end
  end

endmodule

// File: tb/tb_monitor_counters_sampler.sv
module tb_monitor_counters_sampler;
  localparam int AW = 6, DW = 32, NUM_CNT = 8, PW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, trigger = 1'b0, clear_after_read = 1'b0;
  logic [PW-1:0] period = '0;
  logic req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW/8-1:0] req_wstrb;
  logic rsp_ready = 1'b0, rsp_error = 1'b0;
  logic [DW-1:0] rsp_rdata = '0;
  logic [NUM_CNT*DW-1:0] snap_data;
  logic snap_valid, snap_error, busy, overrun;
  logic [15:0] sample_cnt;

  always #5 clk = ~clk;

  monitor_counters_sampler #(.AW(AW), .DW(DW), .NUM_CNT(NUM_CNT), .BASE_ADDR(0), .PERIOD_W(PW)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .period_i(period), .trigger_i(trigger),
    .clear_after_read_i(clear_after_read),
    .req_valid_o(req_valid), .req_write_o(req_write), .req_addr_o(req_addr),
    .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .rsp_ready_i(rsp_ready), .rsp_rdata_i(rsp_rdata), .rsp_error_i(rsp_error),
    .snap_data_o(snap_data), .snap_valid_o(snap_valid), .snap_error_o(snap_error),
    .busy_o(busy), .overrun_o(overrun), .sample_cnt_o(sample_cnt)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic wr; logic [AW-1:0] addr; } tx_t;
  typedef struct { logic [NUM_CNT*DW-1:0] data; logic err; } snap_t;
  tx_t   exp_tx[$];
  snap_t exp_snap[$];
  tx_t   t_m;
  snap_t s_m;

  // slave model / counter contents
  logic [DW-1:0] mem [NUM_CNT];
  int wait_n = 0, err_idx = -1, err_wait = 0, wait_cnt = 0, w_m = 0, idx_m = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_start = 0, n_snap = 0, n_ovr = 0, last_start = -1, start_gap = 0, snap_lat = 0;
  int last_snap_cyc = 0, snap_gap = 0, ovr_at_snap = 0, ovr_between = 0;
  int hold_run = 0, max_hold = 0;
  logic busy_q = 1'b0, prev_vld = 1'b0, prev_rdy = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // monitor + scoreboard + slave, all on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      busy_q = 1'b0; prev_vld = 1'b0; prev_rdy = 1'b0;
      rsp_ready = 1'b0; rsp_error = 1'b0; wait_cnt = 0; hold_run = 0;
    end else begin
      if (busy && !busy_q) begin
        n_start++;
        start_gap  = (last_start < 0) ? 0 : (cyc - 1 - last_start);
        last_start = cyc - 1;
        for (int i = 0; i < NUM_CNT; i++) begin
          t_m.wr = 1'b0; t_m.addr = AW'(i * 4); exp_tx.push_back(t_m);
          if (clear_after_read) begin t_m.wr = 1'b1; exp_tx.push_back(t_m); end
          s_m.data[i*DW +: DW] = mem[i];
        end
        s_m.err = (err_idx >= 0);
        exp_snap.push_back(s_m);
      end
      busy_q = busy;
      if (overrun) n_ovr++;
      if (snap_valid) begin
        n_snap++;
        snap_lat      = cyc - last_start;
        snap_gap      = cyc - last_snap_cyc;
        last_snap_cyc = cyc;
        ovr_between   = n_ovr - ovr_at_snap;
        ovr_at_snap   = n_ovr;
        if (exp_snap.size() == 0) check("snap_unexpected", 1, 0);
        else begin
          s_m = exp_snap.pop_front();
          for (int i = 0; i < NUM_CNT; i++)
            check($sformatf("snap_slot%0d", i), snap_data[i*DW +: DW], s_m.data[i*DW +: DW]);
          check("snap_error", snap_error, s_m.err);
        end
        check("sample_cnt", sample_cnt, 16'(n_snap));
      end
      if (req_valid && prev_vld && !prev_rdy) begin
        hold_run++;
        check("hold_addr", req_addr, prev_addr);
        check("hold_write", req_write, prev_wr);
      end
      rsp_ready = 1'b0; rsp_error = 1'b0;
      if (req_valid) begin
        idx_m = int'(req_addr >> 2);
        w_m   = (!req_write && idx_m == err_idx) ? err_wait : wait_n;
        if (wait_cnt < w_m) wait_cnt++;
        else begin
          wait_cnt  = 0;
          rsp_ready = 1'b1;
          if (hold_run > max_hold) max_hold = hold_run;
          hold_run = 0;
          if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
          else begin
            t_m = exp_tx.pop_front();
            check("tx_addr", req_addr, t_m.addr);
            check("tx_write", req_write, t_m.wr);
            check("tx_wstrb", req_wstrb, t_m.wr ? 4'hF : 4'h0);
            check("tx_wdata", req_wdata, 0);
          end
          if (req_write) mem[idx_m] = '0;
          else begin
            rsp_rdata = mem[idx_m];
            rsp_error = (idx_m == err_idx);
          end
        end
      end
      prev_vld = req_valid; prev_rdy = rsp_ready; prev_addr = req_addr; prev_wr = req_write;
    end
  end

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_snaps(input int n, input int budget, input string tag);
    int k = 0;
    while (n_snap < n && k < budget) begin @(negedge clk); k++; end
    check(tag, (n_snap >= n), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_valid"}, req_valid, 0);
    check({pfx, "_req_write"}, req_write, 0);
    check({pfx, "_req_addr"}, req_addr, 0);
    check({pfx, "_req_wstrb"}, req_wstrb, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_snap_valid"}, snap_valid, 0);
    check({pfx, "_snap_error"}, snap_error, 0);
    check({pfx, "_overrun"}, overrun, 0);
    check({pfx, "_sample_cnt"}, sample_cnt, 0);
    check({pfx, "_snap_data"}, (snap_data == '0), 1);
  endtask

  int n0, s0, o0, k;
  logic found;

  initial begin
    for (int i = 0; i < NUM_CNT; i++) mem[i] = DW'(32'h10 * i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // periodic, no clear
    period = 100; enable = 1'b1;
    wait_snaps(3, 450, "periodic_done");
    check("periodic_latency", snap_lat, 17);
    check("periodic_gap", start_gap, 100);
    check("periodic_no_overrun", n_ovr, 0);
    enable = 1'b0;
    @(negedge clk);

    // clear after read
    clear_after_read = 1'b1;
    mem[3] = 32'hDEAD;
    pulse_trigger();
    wait_snaps(4, 100, "clear_done1");
    check("clear_latency", snap_lat, 33);
    check("clear_slot3", snap_data[3*DW +: DW], 32'hDEAD);
    pulse_trigger();
    wait_snaps(5, 100, "clear_done2");
    check("clear_slot3_zero", snap_data[3*DW +: DW], 0);
    check("clear_slot7_zero", snap_data[7*DW +: DW], 0);
    clear_after_read = 1'b0;

    // backpressure + bus error on counter 2
    for (int i = 0; i < NUM_CNT; i++) mem[i] = DW'(32'h10 * i);
    err_idx = 2; err_wait = 5; max_hold = 0;
    pulse_trigger();
    wait_snaps(6, 100, "err_done");
    check("err_flag", snap_error, 1);
    check("err_hold_cycles", max_hold, 5);
    check("err_slot2_kept", snap_data[2*DW +: DW], 32'h20);
    err_idx = -1;
    pulse_trigger();
    wait_snaps(7, 100, "clean_done");
    check("clean_flag", snap_error, 0);

    // overrun: period 10, 3-wait slave
    wait_n = 3; period = 10; enable = 1'b1;
    wait_snaps(10, 300, "ovr_done");
    enable = 1'b0;
    check("ovr_per_sweep", ovr_between, 4);
    check("ovr_sweep_gap", snap_gap, 50);
    check("ovr_start_gap", start_gap, 50);
    check("ovr_sample_cnt", sample_cnt, 10);
    wait_n = 0;
    repeat (20) @(negedge clk);

    // manual trigger, retrigger while busy
    n0 = n_start; o0 = n_ovr; s0 = n_snap;
    pulse_trigger();
    repeat (4) @(negedge clk);
    pulse_trigger();
    wait_snaps(s0 + 1, 100, "manual_done");
    repeat (200) @(negedge clk);
    check("manual_one_sweep", n_start - n0, 1);
    check("manual_overrun", n_ovr - o0, 1);

    // reset during read of counter 4
    pulse_trigger();
    found = 1'b0; k = 0;
    while (!found && k < 60) begin
      @(negedge clk); k++;
      found = req_valid && (req_addr == 6'h10);
    end
    check("rst_saw_cnt4", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_tx.delete(); exp_snap.delete();
    n_snap = 0; last_start = -1;
    rst = 1'b0;
    @(negedge clk);
    pulse_trigger();
    found = 1'b0; k = 0;
    while (!found && k < 10) begin
      found = req_valid;
      if (!found) begin @(negedge clk); k++; end
    end
    check("post_rst_req", found, 1);
    check("post_rst_addr", req_addr, 0);
    wait_snaps(1, 100, "post_rst_done");
    check("post_rst_cnt", sample_cnt, 1);

    repeat (5) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("snap_queue_empty", exp_snap.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
